// File: rtl/eth_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : eth_tx_sched                                                   |
// | Purpose : Frame-level RGMII TX scheduler. Round-robin arbitration        |
// |           between the NIOS TX buffer (source 0) and the hardware stream  |
// |           buffer (source 1), preamble/SFD insertion, byte streaming      |
// |           from the granted buffer and inter-frame gap enforcement.       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module eth_tx_sched #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1518,
  parameter int PRE_LEN = 7,
  parameter int IFG_LEN = 12
) (
  input  logic              i_tx_clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_req_0,
  input  logic [ADDR_W-1:0] i_len_0,
  input  logic [7:0]        i_rd_data_0,
  output logic              o_done_0,
  input  logic              i_req_1,
  input  logic [ADDR_W-1:0] i_len_1,
  input  logic [7:0]        i_rd_data_1,
  output logic              o_done_1,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_drop,
  output logic              o_tx_en,
  output logic [7:0]        o_tx_data,
  output logic              o_busy,
  output logic              o_grant,
  output logic [15:0]       o_frm_cnt
);

  localparam int PRE_W = $clog2(PRE_LEN + 1);
  localparam int IFG_W = $clog2(IFG_LEN + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_LEN - 1);
  // The IDLE arbitration cycle and the launch cycle that follows a grant
  // both keep tx_en low, so the IFG state itself only needs to cover the
  // remaining IFG_LEN-2 cycles for the wire gap to be exactly IFG_LEN.
  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_LEN - 3);
  localparam logic [ADDR_W-1:0] MAX_LEN_W = ADDR_W'(MAX_LEN);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SFD  = 3'd2,
    DATA = 3'd3,
    IFG  = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] byte_cnt;
  logic [PRE_W-1:0]  pre_cnt;
  logic [IFG_W-1:0]  ifg_cnt;
  logic              last_src;
  logic [15:0]       frm_cnt;

  logic              pick_src;
  logic [ADDR_W-1:0] pick_len;
  logic              pick_bad;
  logic              grant_ok;
  logic              addr_last;
  logic [7:0]        src_data;

  // Round-robin pick and length qualification of the candidate frame.
  always_comb begin
    pick_src = 1'b0;
    pick_len = '0;
    pick_bad = 1'b0;
    grant_ok = 1'b0;
    if (i_req_0 && i_req_1) begin
      pick_src = ~last_src;
    end else begin
      pick_src = i_req_1;
    end
    pick_len = pick_src ? i_len_1 : i_len_0;
    pick_bad = (pick_len == '0) || (pick_len > MAX_LEN_W);
    // A drop pulse blocks re-arbitration for one clock so the requester
    // has a chance to withdraw the rejected request.
    grant_ok = i_enable && (i_req_0 || i_req_1) && !o_drop;
  end

  assign addr_last = (o_rd_addr == (len_r - ONE_A));
  assign src_data  = o_grant ? i_rd_data_1 : i_rd_data_0;
  assign o_frm_cnt = frm_cnt;

  // Frame sequencer; every output is registered here.
  always_ff @(posedge i_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_r     <= '0;
      byte_cnt  <= '0;
      pre_cnt   <= '0;
      ifg_cnt   <= '0;
      last_src  <= 1'b1;
      frm_cnt   <= 16'd0;
      o_done_0  <= 1'b0;
      o_done_1  <= 1'b0;
      o_rd_addr <= '0;
      o_drop    <= 1'b0;
      o_tx_en   <= 1'b0;
      o_tx_data <= 8'h00;
      o_busy    <= 1'b0;
      o_grant   <= 1'b0;
    end else begin
      o_drop   <= 1'b0;
      o_done_0 <= 1'b0;
      o_done_1 <= 1'b0;
      case (state)
        IDLE: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (grant_ok) begin
            o_grant  <= pick_src;
            len_r    <= pick_len;
            last_src <= pick_src;
            if (pick_bad) begin
              o_drop <= 1'b1;
              if (pick_src) begin
                o_done_1 <= 1'b1;
              end else begin
                o_done_0 <= 1'b1;
              end
            end else begin
              // Address 0 is presented now so the first byte is already
              // waiting in the output path when SFD completes.
              state     <= PRE;
              o_busy    <= 1'b1;
              pre_cnt   <= '0;
              o_rd_addr <= '0;
            end
          end
        end

        PRE: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= 8'h55;
          if (pre_cnt == PRE_LAST) begin
            state <= SFD;
          end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
          end
        end

        SFD: begin
          o_tx_en   <= 1'b1;
          o_tx_data <= 8'hD5;
          state     <= DATA;
          byte_cnt  <= '0;
          if (!addr_last) begin
            o_rd_addr <= o_rd_addr + ONE_A;
          end
        end

        DATA: begin
          if (byte_cnt == len_r) begin
            o_tx_en   <= 1'b0;
            o_tx_data <= 8'h00;
            state     <= IFG;
            ifg_cnt   <= '0;
            frm_cnt   <= frm_cnt + 16'd1;
            if (o_grant) begin
              o_done_1 <= 1'b1;
            end else begin
              o_done_0 <= 1'b1;
            end
          end else begin
            o_tx_en   <= 1'b1;
            o_tx_data <= src_data;
            byte_cnt  <= byte_cnt + ONE_A;
            if (!addr_last) begin
              o_rd_addr <= o_rd_addr + ONE_A;
            end
          end
        end

        IFG: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          if (ifg_cnt == IFG_LAST) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt + IFG_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          o_busy  <= 1'b0;
          o_tx_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_eth_tx_sched                                                |
// | Purpose : Directed self-checking bench for eth_tx_sched.                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_eth_tx_sched;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              req_0, req_1;
  logic [ADDR_W-1:0] len_0, len_1;
  logic [7:0]        rd_data_0, rd_data_1;
  logic              done_0, done_1;
  logic [ADDR_W-1:0] rd_addr;
  logic              drop;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              busy;
  logic              grant;
  logic [15:0]       frm_cnt;

  logic [7:0]        mem0 [0:2047];
  logic [7:0]        mem1 [0:2047];

  int                vectors = 0;
  int                miscompares = 0;
  logic [15:0]       exp_cnt = 16'd0;

  // 125 MHz byte clock
  always #4 clk = ~clk;

  // Buffer RAMs with one clock of read latency
  always @(posedge clk) begin
    rd_data_0 <= mem0[rd_addr];
    rd_data_1 <= mem1[rd_addr];
  end

  eth_tx_sched #(
    .ADDR_W (ADDR_W),
    .MAX_LEN(1518),
    .PRE_LEN(7),
    .IFG_LEN(12)
  ) dut (
    .i_tx_clk   (clk),
    .rst_n      (rst_n),
    .i_enable   (enable),
    .i_req_0    (req_0),
    .i_len_0    (len_0),
    .i_rd_data_0(rd_data_0),
    .o_done_0   (done_0),
    .i_req_1    (req_1),
    .i_len_1    (len_1),
    .i_rd_data_1(rd_data_1),
    .o_done_1   (done_1),
    .o_rd_addr  (rd_addr),
    .o_drop     (drop),
    .o_tx_en    (tx_en),
    .o_tx_data  (tx_data),
    .o_busy     (busy),
    .o_grant    (grant),
    .o_frm_cnt  (frm_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Count low tx_en samples (current one included) until tx_en is seen high.
  task automatic wait_tx(output int lows);
    bit ok;
    ok   = 1'b0;
    lows = 0;
    while (!ok && lows < 64) begin
      if (tx_en === 1'b1) ok = 1'b1;
      else begin
        lows++;
        @(negedge clk);
      end
    end
    if (!ok) check("tx_en rise timeout", {31'd0, tx_en}, 32'd1);
  endtask

  // Follow one frame from its first on-wire byte. act 1: disable and post
  // a source-1 request at sample act_at; act 2: assert reset there.
  // Returns positioned on the second low sample after the frame.
  task automatic stream(input bit src, input int len, input int act_at,
                        input int act, output bit aborted);
    int         idx, errs, addr_errs, side_errs;
    logic [7:0] exp;
    idx = 0; errs = 0; addr_errs = 0; side_errs = 0;
    aborted = 1'b0;
    while (tx_en === 1'b1 && idx < 1600 && !aborted) begin
      if (idx < 7) exp = 8'h55;
      else if (idx == 7) exp = 8'hD5;
      else if (src) exp = mem1[idx-8];
      else exp = mem0[idx-8];
      if (tx_data !== exp) errs++;
      if (int'(rd_addr) > len - 1) addr_errs++;
      if (grant !== src || busy !== 1'b1) side_errs++;
      if (idx == act_at) begin
        if (act == 1) begin
          enable = 1'b0;
          len_1  = 11'd30;
          req_1  = 1'b1;
        end else if (act == 2) begin
          rst_n = 1'b0;
          #1;
          check("reset mid-frame tx_en", {31'd0, tx_en}, 32'd0);
          check("reset mid-frame done_0", {31'd0, done_0}, 32'd0);
          check("reset mid-frame frm_cnt", {16'd0, frm_cnt}, 32'd0);
          exp_cnt = 16'd0;
          aborted = 1'b1;
        end
      end
      idx++;
      if (!aborted) @(negedge clk);
    end
    if (!aborted) begin
      check("on-wire cycles", idx, len + 8);
      check("byte stream errors", errs, 0);
      check("rd_addr range errors", addr_errs, 0);
      check("grant/busy errors", side_errs, 0);
      check("done pulse", {31'd0, (src ? done_1 : done_0)}, 32'd1);
      check("other done quiet", {31'd0, (src ? done_0 : done_1)}, 32'd0);
      exp_cnt = exp_cnt + 16'd1;
      check("frame count", {16'd0, frm_cnt}, {16'd0, exp_cnt});
      if (src) req_1 = 1'b0;
      else req_0 = 1'b0;
      @(negedge clk);
      check("done single pulse", {31'd0, (src ? done_1 : done_0)}, 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lows, highs, zerr;
    bit  ab, rs;
    int  rl;

    for (int i = 0; i < 2048; i++) begin
      mem0[i] = i[7:0];
      mem1[i] = 8'hA5 ^ i[7:0];
    end
    rst_n = 1'b0; enable = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0; len_0 = '0; len_1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset tx_en", {31'd0, tx_en}, 32'd0);
    check("reset tx_data", {24'd0, tx_data}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset grant", {31'd0, grant}, 32'd0);
    check("reset frm_cnt", {16'd0, frm_cnt}, 32'd0);
    check("reset done", {30'd0, done_1, done_0}, 32'd0);
    check("reset drop", {31'd0, drop}, 32'd0);
    check("reset rd_addr", {21'd0, rd_addr}, 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    @(negedge clk);

    // Both requests together, twice: 0,1,0,1 with 12-clock gaps
    len_0 = 11'd60; len_1 = 11'd60;
    req_0 = 1'b1; req_1 = 1'b1;
    wait_tx(lows);
    check("launch latency", lows, 2);
    stream(1'b0, 60, -1, 0, ab);
    wait_tx(lows);
    check("gap 0->1", lows + 1, 12);
    stream(1'b1, 60, -1, 0, ab);
    req_0 = 1'b1; req_1 = 1'b1;
    wait_tx(lows);
    check("gap 1->0", lows + 1, 12);
    stream(1'b0, 60, -1, 0, ab);
    wait_tx(lows);
    check("gap 0->1 second", lows + 1, 12);
    stream(1'b1, 60, -1, 0, ab);

    // Source 0 alone, 64 bytes, then a maximum-length frame
    len_0 = 11'd64; req_0 = 1'b1;
    wait_tx(lows);
    check("gap before 64B", lows + 1, 12);
    stream(1'b0, 64, -1, 0, ab);
    len_0 = 11'd1518; req_0 = 1'b1;
    wait_tx(lows);
    stream(1'b0, 1518, -1, 0, ab);
    highs = 0; zerr = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_en !== 1'b0) highs++;
      if (tx_data !== 8'h00) zerr++;
    end
    check("idle after frame tx_en", highs, 0);
    check("idle after frame tx_data", zerr, 0);
    check("idle busy", {31'd0, busy}, 32'd0);

    // Illegal lengths on source 1, then a one-byte frame
    len_1 = 11'd0; req_1 = 1'b1;
    @(negedge clk);
    check("drop len0", {31'd0, drop}, 32'd1);
    check("drop len0 done_1", {31'd0, done_1}, 32'd1);
    check("drop len0 tx_en", {31'd0, tx_en}, 32'd0);
    check("drop len0 frm_cnt", {16'd0, frm_cnt}, {16'd0, exp_cnt});
    req_1 = 1'b0;
    @(negedge clk);
    check("drop pulse width", {31'd0, drop}, 32'd0);
    len_1 = 11'd1519; req_1 = 1'b1;
    @(negedge clk);
    check("drop 1519", {31'd0, drop}, 32'd1);
    check("drop 1519 done_1", {31'd0, done_1}, 32'd1);
    check("drop 1519 busy", {31'd0, busy}, 32'd0);
    req_1 = 1'b0;
    @(negedge clk);
    check("drop 1519 tx_en", {31'd0, tx_en}, 32'd0);
    check("drop 1519 frm_cnt", {16'd0, frm_cnt}, {16'd0, exp_cnt});
    len_1 = 11'd1; req_1 = 1'b1;
    wait_tx(lows);
    stream(1'b1, 1, -1, 0, ab);

    // Enable dropped mid-DATA of a 100-byte frame
    repeat (12) @(negedge clk);
    len_0 = 11'd100; req_0 = 1'b1;
    wait_tx(lows);
    stream(1'b0, 100, 48, 1, ab);
    highs = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_en !== 1'b0) highs++;
    end
    check("no grant while disabled", highs, 0);
    check("disabled busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_tx(lows);
    check("grant after enable latency", lows, 2);
    stream(1'b1, 30, -1, 0, ab);

    // Reset at data byte 20
    repeat (12) @(negedge clk);
    len_0 = 11'd50; req_0 = 1'b1;
    wait_tx(lows);
    stream(1'b0, 50, 28, 2, ab);
    check("reset reached", {31'd0, ab}, 32'd1);
    req_0 = 1'b0;
    repeat (2) @(negedge clk);
    check("in reset busy", {31'd0, busy}, 32'd0);
    check("in reset done", {30'd0, done_1, done_0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    len_0 = 11'd20; req_0 = 1'b1;
    wait_tx(lows);
    check("post-reset launch latency", lows, 2);
    stream(1'b0, 20, -1, 0, ab);

    // Frame counter wrap
    repeat (12) @(negedge clk);
    force dut.frm_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frm_cnt;
    exp_cnt = 16'hFFFF;
    check("frm_cnt preload", {16'd0, frm_cnt}, 32'h0000FFFF);
    len_1 = 11'd10; req_1 = 1'b1;
    wait_tx(lows);
    stream(1'b1, 10, -1, 0, ab);
    check("frm_cnt wrap", {16'd0, frm_cnt}, 32'd0);

    // Randomised back-to-back traffic
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      rl = int'($urandom_range(1, 80));
      for (int a = 0; a < rl; a++) begin
        if (rs) mem1[a] = 8'($urandom);
        else mem0[a] = 8'($urandom);
      end
      if (rs) begin len_1 = 11'(rl); req_1 = 1'b1; end
      else begin len_0 = 11'(rl); req_0 = 1'b1; end
      wait_tx(lows);
      if (k > 0) check("random gap >= 12", {31'd0, (lows + 1 >= 12)}, 32'd1);
      stream(rs, rl, -1, 0, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Frame-level TX scheduler for the RGMII transmit path in the i_tx_clk domain.
- Shares the single byte-wide TX datapath (tx_en / tx_data into the DDR output stage) between two packet buffers: source 0 is the NIOS TX buffer and source 1 is the hardware stream buffer.
- Per frame: arbitrates round-robin, then emits preamble and SFD, then streams buffer bytes, then enforces the inter-frame gap.
- Frames in the buffers already contain the FCS.

Parameters:
- ADDR_W, 11, buffer byte-address width.
- MAX_LEN, 1518, largest accepted frame length in bytes, including FCS.
- PRE_LEN, 7, number of 0x55 preamble bytes.
- IFG_LEN, 12, minimum idle cycles after the last frame byte.

Ports:
- i_tx_clk  in  1  TX byte clock (PLL 90-degree output).
- rst_n  in  1  asynchronous active-low reset (PLL locked).
- i_enable  in  1  scheduler enable, from the command register.
- i_req_0  in  1  source 0 frame request; level, held until o_done_0.
- i_len_0  in  ADDR_W  source 0 frame length in bytes.
- i_rd_data_0  in  8  source 0 buffer read data; valid 1 clk after o_rd_addr.
- o_done_0  out  1  source 0 frame-complete pulse.
- i_req_1  in  1  source 1 frame request; level, held until o_done_1.
- i_len_1  in  ADDR_W  source 1 frame length in bytes.
- i_rd_data_1  in  8  source 1 buffer read data; valid 1 clk after o_rd_addr.
- o_done_1  out  1  source 1 frame-complete pulse.
- o_rd_addr  out  ADDR_W  shared buffer read address.
- o_drop  out  1  pulse: granted frame discarded because of an illegal length.
- o_tx_en  out  1  to the TX DDR stage.
- o_tx_data  out  8  to the TX DDR stage.
- o_busy  out  1  high in every state except IDLE.
- o_grant  out  1  source of the current or last frame.
- o_frm_cnt  out  16  count of transmitted frames.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; last-served source = 1, so source 0 wins the first tie.
- States: IDLE, PRE, SFD, DATA, IFG.
- IDLE, grant rules:
  - Grant only if i_enable=1 and at least one request is high.
  - Only one request high: grant that source.
  - Both high: grant the source not last served.
  - On grant: latch o_grant and the granted source's length into len_r; update last-served.
- IDLE, length check on the latched length:
  - len_r=0 or len_r>MAX_LEN: pulse o_drop and o_done_<src> for 1 clk; no bytes sent; stay in IDLE; no IFG.
  - Otherwise go to PRE.
- PRE: o_tx_en=1, o_tx_data=0x55 for PRE_LEN clocks.
- SFD: o_tx_en=1, o_tx_data=0xD5 for 1 clock.
- DATA:
  - Emits len_r bytes, o_tx_en=1, byte n = granted buffer contents at address n, n = 0..len_r-1, contiguous with no gaps.
  - Address issue leads the output by the 1-clk RAM latency plus the output register, so it must begin during PRE/SFD.
  - o_rd_addr never exceeds len_r-1 and holds its last value afterwards.
- IFG: o_tx_en=0, o_tx_data=0x00 for exactly IFG_LEN clocks, then IDLE.
- Frame completion:
  - o_done_<src> pulses 1 clk on the first IFG cycle.
  - o_frm_cnt increments on the same clock and wraps 0xFFFF -> 0.
- Latency: o_tx_en rises on the clock edge after the one that grants in IDLE. Total on-wire cycles = PRE_LEN + 1 + len_r.
- Output registering: o_tx_en and o_tx_data are registered, with no combinational path from any input.
- Requester rules:
  - Must drop i_req within IFG_LEN clocks of o_done.
  - A request still high when IDLE is re-entered is a new frame.
  - i_len and the buffer contents must be stable from request until o_done.
- Length changes after grant are ignored (len_r is latched).
- i_enable low: blocks new grants only; a frame in progress completes, including IFG.
- Simultaneous events:
  - A request arriving during PRE/SFD/DATA/IFG waits; it is evaluated only in IDLE.
  - Both requests rising on the same IDLE clock are resolved by round-robin.
- Reset mid-frame: o_tx_en drops immediately; no o_done; o_frm_cnt clears.
- len_r=1: one data byte, then IFG.
- len_r=MAX_LEN: full length sent; the address stays within range.

Test Plan:
- Source 0 only, len=64, buffer[n]=n:
  - o_tx_en high 72 clocks: 7x55, D5, then 00..3F.
  - Then 12 idle clocks; o_done_0 single pulse; o_frm_cnt=1.
- Both requests rise together twice after reset, len 60/60:
  - Grant order 0, 1, 0, 1.
  - Every inter-frame o_tx_en-low gap is exactly 12 clocks.
- Source 1 with len=0, then len=1519:
  - Two o_drop pulses, each with o_done_1; o_tx_en stays 0; o_frm_cnt unchanged.
  - len=1 then gives 7x55, D5, 1 byte.
- i_enable deasserted mid-DATA of a 100-byte frame:
  - Frame completes and o_done asserts.
  - A pending request is not granted until i_enable=1.
- rst_n pulled low at data byte 20:
  - o_tx_en=0 immediately, no o_done, o_frm_cnt=0.
  - After reset the next request starts a clean preamble.
- Preload o_frm_cnt to 0xFFFF via 65535 short frames (or force) and send one frame:
  - o_frm_cnt=0x0000.
  - Randomised back-to-back traffic: the byte stream matches buffer contents and no gap is shorter than 12 clocks.
